receiver_top_module: RTL and testbench

RECEIVER_TOP_MODULE -- requirements
Module: receiver_top_module

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_tick_gen.sv | 38 +++
 rtl/receiver_top_module.sv | 170 +++++++++++++++++
 tb/tb_receiver_top_module.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, status bit
// positions, oversampling and frame constants.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int STAT_DATA_VALID  = 0;
    localparam int STAT_FRAMING_ERR = 1;
    localparam int STAT_OVERRUN_ERR = 2;
    localparam int STAT_BUSY        = 3;

    // A divisor of zero would never wrap; run it as divide-by-one instead.
    function automatic logic [31:0] eff_divisor(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample prescaler: counts 0..N-1 and pulses tick for one
// clk at N-1. The divisor is captured only at the wrap so a software update
// never produces a short or runaway period.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] divisor,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;

    // Wrap detection, counter advance and divisor capture at the wrap.
    always_comb begin
        tick  = (cnt_q == (div_q - 32'd1));
        cnt_d = cnt_q + 32'd1;
        div_d = div_q;
        if (tick) begin
            cnt_d = 32'd0;
            div_d = eff_divisor(divisor);
        end
    end

    // Counter and active divisor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
            div_q <= 32'd1;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/receiver_top_module.sv
// UART 8N1 receiver with 16x oversampling, a single-entry holding register
// and sticky error status.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a tick that sees RX low
// ST_START | counting to mid start bit to reject glitches
// ST_DATA  | sampling 8 data bits every 16 ticks, LSB first
// ST_STOP  | waiting for mid stop bit, then delivering the byte
module receiver_top_module
    import uart_pkg::*;
#(
    parameter int unsigned clock_frequency_register = 'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic [31:0] Baud_Rate_Holding_Register,
    input  logic        Receiver_Read_Ack,
    output logic [31:0] Receiver_Holding_Register,
    output logic [31:0] Receiver_Status
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic      tick;
    rx_state_e state_q, state_d;
    logic      rx_meta_q, rx_meta_d;
    logic      rx_sync_q, rx_sync_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] holding_q, holding_d;
    logic      data_valid_q, data_valid_d;
    logic      framing_err_q, framing_err_d;
    logic      overrun_err_q, overrun_err_d;
    logic      busy;
    logic      sample_point;
    logic      start_mid;
    logic      byte_done;

    uart_rx_tick_gen u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (Baud_Rate_Holding_Register),
        .tick    (tick)
    );

    assign sample_point = tick && (tick_cnt_q == LAST_TICK);
    assign start_mid    = tick && (tick_cnt_q == MID_TICK);
    assign byte_done    = (state_q == ST_STOP) && sample_point;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tick && !rx_sync_q) state_d = ST_START;
            ST_START: if (start_mid) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample_point && (bit_cnt_q == LAST_BIT)) state_d = ST_STOP;
            ST_STOP:  if (sample_point) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
        Receiver_Holding_Register = {24'd0, holding_q};
        Receiver_Status = 32'd0;
        Receiver_Status[STAT_DATA_VALID]  = data_valid_q;
        Receiver_Status[STAT_FRAMING_ERR] = framing_err_q;
        Receiver_Status[STAT_OVERRUN_ERR] = overrun_err_q;
        Receiver_Status[STAT_BUSY]        = busy;
    end

    // Synchronizer, oversample/bit counters and LSB-first shift register.
    always_comb begin
        rx_meta_d  = RX;
        rx_sync_d  = rx_meta_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && !rx_sync_q) tick_cnt_d = 4'd0;
            end
            ST_START: begin
                if (start_mid) begin
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            ST_DATA: begin
                // The 4-bit counter wraps 15->0, so STOP starts from zero.
                if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
                if (sample_point) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
            end
            default: tick_cnt_d = 4'd0;
        endcase
    end

    // Holding register and sticky status; a read ack in the completion
    // cycle acknowledges the old byte, so the new byte starts clean.
    always_comb begin
        holding_d     = holding_q;
        data_valid_d  = data_valid_q;
        framing_err_d = framing_err_q;
        overrun_err_d = overrun_err_q;
        if (byte_done) begin
            holding_d    = shift_q;
            data_valid_d = 1'b1;
            if (Receiver_Read_Ack) begin
                framing_err_d = !rx_sync_q;
                overrun_err_d = 1'b0;
            end else begin
                framing_err_d = framing_err_q | !rx_sync_q;
                overrun_err_d = overrun_err_q | data_valid_q;
            end
        end else if (Receiver_Read_Ack) begin
            data_valid_d  = 1'b0;
            framing_err_d = 1'b0;
            overrun_err_d = 1'b0;
        end
    end

    // Datapath registers; synchronizer resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            tick_cnt_q    <= 4'd0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            holding_q     <= 8'd0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            holding_q     <= holding_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

endmodule

// File: tb/tb_receiver_top_module.sv
// Directed bench for receiver_top_module: frames are driven on clk negedges,
// outputs sampled 1 time unit after posedge.
module tb_receiver_top_module;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic [31:0] Baud_Rate_Holding_Register;
    logic        Receiver_Read_Ack;
    logic [31:0] Receiver_Holding_Register;
    logic [31:0] Receiver_Status;

    int checks = 0;
    int errors = 0;
    int n_div  = 54;

    receiver_top_module #(.clock_frequency_register('d100_000_000)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .RX                         (RX),
        .Baud_Rate_Holding_Register (Baud_Rate_Holding_Register),
        .Receiver_Read_Ack          (Receiver_Read_Ack),
        .Receiver_Holding_Register  (Receiver_Holding_Register),
        .Receiver_Status            (Receiver_Status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        @(negedge clk);
        RX = 1'b0;
        hold(16 * n_div);
        for (int i = 0; i < 8; i++) begin
            RX = v[i];
            hold(16 * n_div);
        end
        RX = stop_bit;
        hold(16 * n_div);
        RX = 1'b1;
        hold(32 * n_div);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        Receiver_Read_Ack = 1'b1;
        @(negedge clk);
        Receiver_Read_Ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the first cycle busy is seen high.
    task automatic wait_busy(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (Receiver_Status[3]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sample_and_check(input string tag, input logic [31:0] exp_hold,
                                    input logic [31:0] exp_stat);
        @(posedge clk);
        #1;
        check({tag, "_holding"}, Receiver_Holding_Register, exp_hold);
        check({tag, "_status"},  Receiver_Status, exp_stat);
    endtask

    initial begin
        logic ok;
        int   busy_cycles;

        rst_n = 1'b0;
        RX = 1'b1;
        Receiver_Read_Ack = 1'b0;
        Baud_Rate_Holding_Register = 32'd54;
        n_div = 54;
        hold(5);
        #1;
        check("reset_holding", Receiver_Holding_Register, 32'h0);
        check("reset_status",  Receiver_Status, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(4 * n_div);

        // 0xA5 at N=54, with exact data_valid latency after the stop sample.
        fork
            send_byte(8'hA5, 1'b1);
            begin
                wait_busy(4 * n_div, ok);
                check("a5_start_seen", {31'd0, ok}, 32'd1);
                repeat (152 * n_div - 1) @(posedge clk);
                #1;
                check("a5_dv_before", {31'd0, Receiver_Status[0]}, 32'd0);
                @(posedge clk);
                #1;
                check("a5_dv_after", {31'd0, Receiver_Status[0]}, 32'd1);
            end
        join
        sample_and_check("a5", 32'h0000_00A5, 32'h0000_0001);
        pulse_ack();
        check("a5_ack_status", Receiver_Status, 32'h0);

        // Faster line for the remaining frames; wait out the old period.
        Baud_Rate_Holding_Register = 32'd8;
        hold(2 * n_div);
        n_div = 8;

        // False start: low for 4 ticks only.
        busy_cycles = 0;
        fork
            begin
                @(negedge clk);
                RX = 1'b0;
                hold(4 * n_div);
                RX = 1'b1;
            end
            begin
                for (int i = 0; i < 20 * n_div; i++) begin
                    @(posedge clk);
                    #1;
                    if (Receiver_Status[3]) busy_cycles++;
                end
            end
        join
        check("false_busy_seen", {31'd0, (busy_cycles > 0)}, 32'd1);
        check("false_busy_len_ok", {31'd0, (busy_cycles <= 8 * n_div)}, 32'd1);
        sample_and_check("false_start", 32'h0000_00A5, 32'h0);

        // Bad stop bit.
        send_byte(8'h3C, 1'b0);
        sample_and_check("frame_err", 32'h0000_003C, 32'h0000_0003);
        pulse_ack();
        check("frame_err_ack", Receiver_Status, 32'h0);

        // Overrun: two bytes without an ack, newest wins.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        sample_and_check("overrun", 32'h0000_0022, 32'h0000_0005);
        pulse_ack();
        check("overrun_ack", Receiver_Status, 32'h0);

        // Ack landing in the completion cycle of the second byte.
        send_byte(8'h11, 1'b1);
        sample_and_check("pre_coinc", 32'h0000_0011, 32'h0000_0001);
        fork
            send_byte(8'h22, 1'b1);
            begin
                wait_busy(4 * n_div, ok);
                check("coinc_start_seen", {31'd0, ok}, 32'd1);
                repeat (152 * n_div - 1) @(posedge clk);
                #1;
                Receiver_Read_Ack = 1'b1;
                @(posedge clk);
                #1;
                Receiver_Read_Ack = 1'b0;
            end
        join
        sample_and_check("coinc", 32'h0000_0022, 32'h0000_0001);

        // Reset in the middle of bit 4 of a frame, with data_valid still set.
        @(negedge clk);
        RX = 1'b0;
        hold(16 * n_div);
        for (int i = 0; i < 4; i++) begin
            RX = 1'b1;
            hold(16 * n_div);
        end
        RX = 1'b0;
        hold(8 * n_div);
        #1;
        check("pre_reset_status", Receiver_Status, 32'h0000_0009);
        rst_n = 1'b0;
        #1;
        check("midreset_holding", Receiver_Holding_Register, 32'h0);
        check("midreset_status",  Receiver_Status, 32'h0);
        RX = 1'b1;
        hold(5);
        rst_n = 1'b1;
        hold(4 * n_div);
        send_byte(8'h5A, 1'b1);
        sample_and_check("after_reset", 32'h0000_005A, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
